led_blink_master: RTL and testbench

Avalon-MM initiator that drives a PIO output slave, such as the LED port, without a CPU. A programmable down-counter produces periodic ticks. On each tick the block writes the next value of an LED_W-bit pattern counter to the slave, reads it back, and compares the result. Mismatches are flagged and counted for board bring-up and self-test.

---
 rtl/led_blink_master.sv | 201 ++++++++++++++++++++
 tb/tb_led_blink_master.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_blink_master.sv
// -----------------------------------------------------------------------------
// led_blink_master
//
// This Avalon-MM initiator drives a PIO output slave, such as an LED port,
// without a CPU. A programmable down-counter generates periodic ticks. On each
// tick the block:
//   1. writes the next value of an LED_W-bit pattern counter to the slave,
//   2. reads the same register back,
//   3. compares the readback with the pattern that was written.
// A readback that differs sets a sticky mismatch flag and increments a
// saturating error counter. These are used for board bring-up and self-test.
//
// Ports
//   clk              clock
//   reset_n          asynchronous, active-low reset
//   enable           level; 1 = run the periodic write/read/check sequence
//   div_load         pulse; latch div_value as the new tick divider
//   div_value        new divider period in clk cycles (0 is stored as 1)
//   avm_address      Avalon address (always TARGET_ADDR)
//   avm_chipselect   Avalon select, high in WRITE and READ only
//   avm_write_n      0 = write, 1 = read while selected
//   avm_writedata    write data, zero-extended pattern value
//   avm_readdata     read data from the slave
//   avm_waitrequest  slave stall
//   pattern          last pattern the slave accepted
//   busy             high in WRITE, READ and CHECK
//   mismatch         sticky readback-compare failure flag
//   err_count        saturating count of readback mismatches
// -----------------------------------------------------------------------------
module led_blink_master #(
    parameter int unsigned LED_W       = 2,
    parameter int unsigned ADDR_W      = 2,
    parameter int unsigned TARGET_ADDR = 0,
    parameter int unsigned DIV_W       = 26,
    parameter int unsigned DEFAULT_DIV = 50000000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              div_load,
    input  logic [DIV_W-1:0]  div_value,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest,
    output logic [LED_W-1:0]  pattern,
    output logic              busy,
    output logic              mismatch,
    output logic [7:0]        err_count
);

    // FSM encoding
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_TICK = 3'd1;
    localparam logic [2:0] S_WRITE     = 3'd2;
    localparam logic [2:0] S_READ      = 3'd3;
    localparam logic [2:0] S_CHECK     = 3'd4;

    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
    // A zero divider is meaningless, so it is clamped to 1 in the same way
    // as a runtime load of 0.
    localparam logic [DIV_W-1:0] RESET_DIV =
        (DEFAULT_DIV == 0) ? DIV_ONE : DIV_W'(DEFAULT_DIV);
    localparam logic [ADDR_W-1:0] ADDR     = ADDR_W'(TARGET_ADDR);

    logic [2:0]       state;
    logic [2:0]       state_next;
    logic [DIV_W-1:0] divider;
    logic [DIV_W-1:0] timer;
    logic [LED_W-1:0] pattern_next;
    logic [LED_W-1:0] captured;
    logic             write_done;
    logic             read_done;
    logic             compare_fail;

    // The pattern wraps naturally at 2^LED_W.
    assign pattern_next = pattern + LED_W'(1);
    assign write_done   = (state == S_WRITE) && !avm_waitrequest;
    assign read_done    = (state == S_READ)  && !avm_waitrequest;
    assign compare_fail = (state == S_CHECK) && (captured != pattern);

    // ---------------------------------------------------------------------
    // Next-state logic. Once WRITE has started, the transaction always runs
    // through READ and CHECK. enable is only consulted in IDLE, WAIT_TICK
    // and when leaving CHECK, so the bus is never left mid-cycle.
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (enable) state_next = S_WAIT_TICK;
            end
            S_WAIT_TICK: begin
                if (!enable)            state_next = S_IDLE;
                else if (timer == '0)   state_next = S_WRITE;
            end
            S_WRITE: begin
                if (!avm_waitrequest)   state_next = S_READ;
            end
            S_READ: begin
                if (!avm_waitrequest)   state_next = S_CHECK;
            end
            S_CHECK: begin
                state_next = enable ? S_WAIT_TICK : S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    // ---------------------------------------------------------------------
    // Divider register. A new value goes into effect only at the next timer
    // reload, because the timer never reads div_value directly.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            divider <= RESET_DIV;
        end else if (div_load) begin
            divider <= (div_value == '0) ? DIV_ONE : div_value;
        end
    end

    // ---------------------------------------------------------------------
    // Tick timer. It counts down only while waiting for a tick. In every
    // other state it is held at divider-1. Because of this, each entry to
    // WAIT_TICK starts a full period, and a tick that would have fallen
    // inside a transaction is dropped instead of queued.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer <= RESET_DIV - DIV_ONE;
        end else if ((state == S_WAIT_TICK) && enable && (timer != '0)) begin
            timer <= timer - DIV_ONE;
        end else begin
            timer <= divider - DIV_ONE;
        end
    end

    // ---------------------------------------------------------------------
    // Pattern advances only on the cycle the slave accepts the write.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pattern <= '0;
        end else if (write_done) begin
            pattern <= pattern_next;
        end
    end

    // Readback capture on the first non-stalled READ cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            captured <= '0;
        end else if (read_done) begin
            captured <= avm_readdata[LED_W-1:0];
        end
    end

    // ---------------------------------------------------------------------
    // Error reporting. Both outputs are sticky until reset. The counter
    // stops at 255 so a long soak cannot wrap it back to a clean reading.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mismatch  <= 1'b0;
            err_count <= '0;
        end else if (compare_fail) begin
            mismatch <= 1'b1;
            if (err_count != '1) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Bus outputs are decoded from the state register. Because of this,
    // an asynchronous reset removes chipselect at once, without waiting for
    // a clock edge.
    // ---------------------------------------------------------------------
    assign avm_address    = ADDR;
    assign avm_chipselect = (state == S_WRITE) || (state == S_READ);
    assign avm_write_n    = (state != S_WRITE);
    assign avm_writedata  = (state == S_WRITE) ? 32'(pattern_next) : '0;
    assign busy           = (state == S_WRITE) || (state == S_READ) ||
                            (state == S_CHECK);

    // Only the low LED_W bits of the readback are compared.
    generate
        if (LED_W < 32) begin : g_readdata_hi
            logic unused_readdata_hi;
            assign unused_readdata_hi = ^avm_readdata[31:LED_W];
        end
    endgenerate

endmodule

// File: tb/tb_led_blink_master.sv
// -----------------------------------------------------------------------------
// tb_led_blink_master
//
// Directed testbench for led_blink_master, with DEFAULT_DIV set to 10. A
// small PIO slave model supplies waitrequest stalls and readback faults.
// Inputs are driven and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_led_blink_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        div_load;
    logic [25:0] div_value;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic [1:0]  pattern;
    logic        busy;
    logic        mismatch;
    logic [7:0]  err_count;

    int vectors     = 0;
    int miscompares = 0;

    // Slave model controls
    int          stall_req  = 0;   // waitrequest cycles inserted on each write
    int          stall_seen = 0;
    int          rd_fault   = 0;   // 0 = clean, 1 = bit0 stuck at 0, 2 = inverted
    logic [31:0] pio        = '0;

    logic [1:0]  pat;              // expected pattern before the next write
    logic [7:0]  err_exp;

    always #5 clk = ~clk;

    led_blink_master #(
        .LED_W       (2),
        .ADDR_W      (2),
        .TARGET_ADDR (0),
        .DIV_W       (26),
        .DEFAULT_DIV (10)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .enable          (enable),
        .div_load        (div_load),
        .div_value       (div_value),
        .avm_address     (avm_address),
        .avm_chipselect  (avm_chipselect),
        .avm_write_n     (avm_write_n),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .pattern         (pattern),
        .busy            (busy),
        .mismatch        (mismatch),
        .err_count       (err_count)
    );

    // PIO slave: one 32-bit register with optional write stall and read faults
    assign avm_waitrequest = avm_chipselect && !avm_write_n && (stall_seen < stall_req);

    always @(posedge clk) begin
        if (avm_chipselect && !avm_write_n && !avm_waitrequest) pio <= avm_writedata;
        if (avm_chipselect && !avm_write_n) stall_seen <= stall_seen + 1;
        else                                stall_seen <= 0;
    end

    always_comb begin
        avm_readdata = pio;
        case (rd_fault)
            1:       avm_readdata = pio & ~32'h1;
            2:       avm_readdata = ~pio;
            default: avm_readdata = pio;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Count falling edges until a write is presented, with a bounded wait.
    task automatic wait_write(input int gap);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(avm_chipselect && !avm_write_n) && n < 64);
        chk("tick_gap", n, gap);
    endtask

    // One write/read/check transaction, ending on the cycle after CHECK.
    task automatic txn(input int gap, input int stall, input logic [1:0] pat_before,
                       input logic mm, input logic [7:0] err, input logic drop_en);
        logic [1:0] pat_after;
        pat_after = pat_before + 2'd1;
        wait_write(gap);
        for (int i = 0; i <= stall; i++) begin
            if (i > 0) @(negedge clk);
            chk("wr_cs",      avm_chipselect, 1);
            chk("wr_write_n", avm_write_n, 0);
            chk("wr_addr",    avm_address, 0);
            chk("wr_data",    avm_writedata, {30'b0, pat_after});
            chk("wr_pattern", pattern, pat_before);
            chk("wr_busy",    busy, 1);
        end
        if (drop_en) enable = 1'b0;
        @(negedge clk);
        chk("rd_cs",      avm_chipselect, 1);
        chk("rd_write_n", avm_write_n, 1);
        chk("rd_pattern", pattern, pat_after);
        @(negedge clk);
        chk("ck_cs",   avm_chipselect, 0);
        chk("ck_busy", busy, 1);
        @(negedge clk);
        chk("post_busy",     busy, 0);
        chk("post_cs",       avm_chipselect, 0);
        chk("post_mismatch", mismatch, mm);
        chk("post_err",      err_count, err);
    endtask

    initial begin
        reset_n   = 1'b0;
        enable    = 1'b0;
        div_load  = 1'b0;
        div_value = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_cs",       avm_chipselect, 0);
        chk("rst_write_n",  avm_write_n, 1);
        chk("rst_addr",     avm_address, 0);
        chk("rst_wdata",    avm_writedata, 0);
        chk("rst_pattern",  pattern, 0);
        chk("rst_busy",     busy, 0);
        chk("rst_mismatch", mismatch, 0);
        chk("rst_err",      err_count, 0);

        // Periodic writes with divider 10: 1, 2, 3, 0, 1
        reset_n = 1'b1;
        enable  = 1'b1;
        pat     = 2'd0;
        err_exp = 8'd0;
        txn(11, 0, pat, 0, 0, 0); pat++;
        for (int k = 0; k < 4; k++) begin
            txn(10, 0, pat, 0, 0, 0);
            pat++;
        end

        // Write stalled for 3 cycles
        stall_req = 3;
        txn(10, 3, pat, 0, 0, 0); pat++;
        stall_req = 0;

        // Readback bit0 stuck at 0: write 3 fails, write 0 matches
        rd_fault = 1;
        txn(10, 0, pat, 1, 1, 0); pat++;
        txn(10, 0, pat, 1, 1, 0); pat++;
        rd_fault = 0;
        err_exp  = 8'd1;

        // div_value=0 loaded mid-countdown: current tick unchanged, then 4-cycle period
        div_load  = 1'b1;
        div_value = '0;
        @(negedge clk);
        div_load  = 1'b0;
        txn(9, 0, pat, 1, err_exp, 0); pat++;
        for (int k = 0; k < 3; k++) begin
            txn(1, 0, pat, 1, err_exp, 0);
            pat++;
        end

        // Forced mismatches drive the error counter to saturation
        rd_fault = 2;
        for (int k = 0; k < 300; k++) begin
            if (err_exp != 8'hFF) err_exp = err_exp + 8'd1;
            txn(1, 0, pat, 1, err_exp, 0);
            pat++;
        end
        chk("err_saturated", err_count, 255);
        rd_fault = 0;

        // enable dropped during WRITE: transaction completes, then IDLE
        txn(1, 0, pat, 1, 8'hFF, 1); pat++;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("idle_cs", avm_chipselect, 0);
        end
        div_load  = 1'b1;
        div_value = 26'd10;
        @(negedge clk);
        div_load  = 1'b0;
        @(negedge clk);
        enable    = 1'b1;

        // Re-enable waits a full period; reset is asserted during READ
        wait_write(11);
        chk("re_wdata", avm_writedata, {30'b0, pat + 2'd1});
        @(negedge clk);
        chk("re_rd_cs", avm_chipselect, 1);
        reset_n = 1'b0;
        #1;
        chk("arst_cs",       avm_chipselect, 0);
        chk("arst_write_n",  avm_write_n, 1);
        chk("arst_pattern",  pattern, 0);
        chk("arst_err",      err_count, 0);
        chk("arst_mismatch", mismatch, 0);
        chk("arst_busy",     busy, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        pat     = 2'd0;
        txn(11, 0, pat, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
